// File: rtl/meas_id_tx_if.sv
// meas_id_tx_if: bundles the measurement-side ID inputs, the host resend
// request and the serial-link outputs of meas_id_tx.
//   master : measurement stage / host side (drives ID, valid, resend)
//   slave  : the transmitter itself
interface meas_id_tx_if #(
  parameter int C_IDWIDTH = 24
);
  logic [C_IDWIDTH-1:0] id;
  logic                 id_v;
  logic                 resend;
  logic                 txd;
  logic                 busy;
  logic                 done;

  modport master (
    output id,
    output id_v,
    output resend,
    input  txd,
    input  busy,
    input  done
  );

  modport slave (
    input  id,
    input  id_v,
    input  resend,
    output txd,
    output busy,
    output done
  );
endinterface

// File: rtl/meas_id_tx.sv
// meas_id_tx: captures the primitive PUF ID on the rising edge of the
// measurement stage's ID-valid level and shifts it out over a single-wire
// UART-style link, least significant byte first, one 8N1 frame per byte.
// A shadow copy of the ID is kept so the host can request a retransmission
// without re-running the measurement.
//
// Build option:
//   MEAS_ID_PARITY_EN - when defined, every frame carries an even-parity bit
//                       between the last data bit and the stop bit (11-bit
//                       frames). When undefined, frames are plain 8N1.
module meas_id_tx #(
  parameter int C_IDWIDTH  = 24,
  parameter int C_BITCYC   = 16,
  parameter int C_CNTWIDTH = 16
) (
  input  logic          I_sclk,
  input  logic          I_osc_rst,
  meas_id_tx_if.slave   bus
);

  localparam int C_NBYTES = C_IDWIDTH / 8;
  localparam int C_BYTEW  = (C_NBYTES > 1) ? $clog2(C_NBYTES) : 1;

  localparam logic [C_CNTWIDTH-1:0] C_CNT_LAST  = C_CNTWIDTH'(C_BITCYC - 1);
  localparam logic [C_BYTEW-1:0]    C_BYTE_LAST = C_BYTEW'(C_NBYTES - 1);
  localparam logic [C_BYTEW-1:0]    C_BYTE_ONE  = C_BYTEW'(1);
  localparam logic [C_BYTEW-1:0]    C_BYTE_ZERO = C_BYTEW'(0);
  localparam logic [C_CNTWIDTH-1:0] C_CNT_ZERO  = C_CNTWIDTH'(0);
  localparam logic [C_CNTWIDTH-1:0] C_CNT_ONE   = C_CNTWIDTH'(1);

`ifdef MEAS_ID_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  // Select byte 'idx' of the ID word.
  function automatic logic [7:0] byte_sel(
    input logic [C_IDWIDTH-1:0] word,
    input logic [C_BYTEW-1:0]   idx
  );
    logic [7:0] res;
    res = 8'h00;
    for (int i = 0; i < C_NBYTES; i++) begin
      if (idx == C_BYTEW'(i)) begin
        res = word[i*8 +: 8];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef MEAS_ID_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  state_t                 state_r, state_n_s;
  logic [C_CNTWIDTH-1:0]  cnt_r, cnt_n_s;
  logic [C_BYTEW-1:0]     byte_r, byte_n_s;
  logic [2:0]             bit_r, bit_n_s;
  logic [C_IDWIDTH-1:0]   shadow_r, shadow_n_s;
  logic                   captured_r, captured_n_s;
  logic                   id_v_d_r;
  logic                   txd_r, txd_n_s;
  logic                   busy_r;
  logic                   done_r, done_n_s;

  logic                   rise_s;
  logic                   bit_end_s;
  logic [7:0]             cur_byte_s;

  assign rise_s    = bus.id_v & ~id_v_d_r;
  assign bit_end_s = (cnt_r == C_CNT_LAST);

  // Next-state, counters and capture decisions for the frame sequencer.
  always_comb begin
    state_n_s    = state_r;
    cnt_n_s      = cnt_r;
    byte_n_s     = byte_r;
    bit_n_s      = bit_r;
    shadow_n_s   = shadow_r;
    captured_n_s = captured_r;
    done_n_s     = 1'b0;

    // The bit-period counter only runs while a frame is on the wire and
    // restarts at every bit boundary, so each state lasts C_BITCYC cycles.
    if (state_r == ST_IDLE) begin
      cnt_n_s = C_CNT_ZERO;
    end else if (bit_end_s) begin
      cnt_n_s = C_CNT_ZERO;
    end else begin
      cnt_n_s = cnt_r + C_CNT_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        // A fresh ID always takes priority over a resend request.
        if (rise_s) begin
          shadow_n_s   = bus.id;
          captured_n_s = 1'b1;
          state_n_s    = ST_START;
          byte_n_s     = C_BYTE_ZERO;
        end else if (bus.resend && captured_r) begin
          state_n_s    = ST_START;
          byte_n_s     = C_BYTE_ZERO;
        end else begin
          state_n_s    = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          state_n_s = ST_DATA;
          bit_n_s   = 3'd0;
        end else begin
          state_n_s = ST_START;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_r == 3'd7) begin
`ifdef MEAS_ID_PARITY_EN
            state_n_s = ST_PAR;
`else
            state_n_s = ST_STOP;
`endif
          end else begin
            bit_n_s = bit_r + 3'd1;
          end
        end else begin
          state_n_s = ST_DATA;
        end
      end

`ifdef MEAS_ID_PARITY_EN
      ST_PAR: begin
        if (bit_end_s) begin
          state_n_s = ST_STOP;
        end else begin
          state_n_s = ST_PAR;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end_s) begin
          // Frames of one ID follow each other with no idle gap.
          if (byte_r == C_BYTE_LAST) begin
            state_n_s = ST_IDLE;
            byte_n_s  = C_BYTE_ZERO;
            done_n_s  = 1'b1;
          end else begin
            state_n_s = ST_START;
            byte_n_s  = byte_r + C_BYTE_ONE;
          end
        end else begin
          state_n_s = ST_STOP;
        end
      end

      default: begin
        state_n_s = ST_IDLE;
        cnt_n_s   = C_CNT_ZERO;
        byte_n_s  = C_BYTE_ZERO;
        bit_n_s   = 3'd0;
      end
    endcase
  end

  // Line level for the upcoming state, registered alongside the state.
  always_comb begin
    txd_n_s    = 1'b1;
    cur_byte_s = byte_sel(shadow_r, byte_n_s);
    case (state_n_s)
      ST_IDLE:  txd_n_s = 1'b1;
      ST_START: txd_n_s = 1'b0;
      ST_DATA:  txd_n_s = cur_byte_s[bit_n_s];
`ifdef MEAS_ID_PARITY_EN
      ST_PAR:   txd_n_s = even_parity(cur_byte_s);
`endif
      ST_STOP:  txd_n_s = 1'b1;
      default:  txd_n_s = 1'b1;
    endcase
  end

  // State, counters, shadow ID and registered outputs.
  always_ff @(posedge I_sclk or negedge I_osc_rst) begin
    if (!I_osc_rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= C_CNT_ZERO;
      byte_r     <= C_BYTE_ZERO;
      bit_r      <= 3'd0;
      shadow_r   <= {C_IDWIDTH{1'b0}};
      captured_r <= 1'b0;
      id_v_d_r   <= 1'b0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      cnt_r      <= cnt_n_s;
      byte_r     <= byte_n_s;
      bit_r      <= bit_n_s;
      shadow_r   <= shadow_n_s;
      captured_r <= captured_n_s;
      id_v_d_r   <= bus.id_v;
      txd_r      <= txd_n_s;
      busy_r     <= (state_n_s != ST_IDLE);
      done_r     <= done_n_s;
    end
  end

  assign bus.txd  = txd_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
